// File: rtl/multicycle_ctrl.sv
// Main control FSM of a multicycle MIPS-like core: sequences FETCH/DECODE/EXEC/MEM/WB and
// drives the datapath strobes and selects for each instruction class.
module multicycle_ctrl #(
    parameter logic [5:0] HALT_FUNCT = 6'h0C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_iord,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wb_sel,
    output logic [1:0]  ext_sel,
    output logic        alu_src_b,
    output logic [3:0]  alu_op,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5
    } state_e;

    localparam logic [3:0] OpAdd = 4'd0, OpSub = 4'd1, OpAnd = 4'd2, OpOr  = 4'd3, OpXor = 4'd4;
    localparam logic [3:0] OpSlt = 4'd5, OpSll = 4'd6, OpSrl = 4'd7, OpSra = 4'd8, OpLui = 4'd9;

    state_e     state_q;
    logic       halted_q, illegal_q;

    logic [5:0] opcode, funct;
    logic       is_rtype, is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
    logic       is_halt, legal, dec_src_b;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_ext;

    // Operand fields are consumed by the datapath, not by the controller.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[25:6];

    assign opcode   = ir[31:26];
    assign funct    = ir[5:0];
    assign is_rtype = (opcode == 6'h00);

    always_comb begin
        is_alu     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        is_halt    = 1'b0;
        legal      = 1'b1;
        dec_alu_op = OpAdd;
        dec_ext    = 2'd3;
        dec_src_b  = 1'b0;
        if (is_rtype && funct == HALT_FUNCT) begin
            is_halt = 1'b1;
        end else begin
            case (opcode)
                6'h00: begin
                    is_alu = 1'b1;
                    case (funct)
                        6'h20, 6'h21: dec_alu_op = OpAdd;
                        6'h22, 6'h23: dec_alu_op = OpSub;
                        6'h24:        dec_alu_op = OpAnd;
                        6'h25:        dec_alu_op = OpOr;
                        6'h26:        dec_alu_op = OpXor;
                        6'h2A:        dec_alu_op = OpSlt;
                        6'h00, 6'h02, 6'h03: begin
                            // Shift amount reaches the ALU through the extender.
                            dec_alu_op = (funct == 6'h00) ? OpSll :
                                         (funct == 6'h02) ? OpSrl : OpSra;
                            dec_ext    = 2'd2;
                            dec_src_b  = 1'b1;
                        end
                        6'h08: begin
                            is_alu = 1'b0;
                            is_jr  = 1'b1;
                        end
                        default: begin
                            is_alu = 1'b0;
                            legal  = 1'b0;
                        end
                    endcase
                end
                6'h08, 6'h09: begin is_alu = 1'b1; dec_ext = 2'd1; dec_src_b = 1'b1; end
                6'h0A: begin is_alu = 1'b1; dec_ext = 2'd1; dec_src_b = 1'b1; dec_alu_op = OpSlt; end
                6'h0C: begin is_alu = 1'b1; dec_ext = 2'd0; dec_src_b = 1'b1; dec_alu_op = OpAnd; end
                6'h0D: begin is_alu = 1'b1; dec_ext = 2'd0; dec_src_b = 1'b1; dec_alu_op = OpOr;  end
                6'h0E: begin is_alu = 1'b1; dec_ext = 2'd0; dec_src_b = 1'b1; dec_alu_op = OpXor; end
                6'h0F: begin is_alu = 1'b1; dec_ext = 2'd0; dec_src_b = 1'b1; dec_alu_op = OpLui; end
                6'h23: begin is_lw  = 1'b1; dec_ext = 2'd1; dec_src_b = 1'b1; end
                6'h2B: begin is_sw  = 1'b1; dec_ext = 2'd1; dec_src_b = 1'b1; end
                6'h04: begin is_beq = 1'b1; dec_ext = 2'd1; dec_alu_op = OpSub; end
                6'h05: begin is_bne = 1'b1; dec_ext = 2'd1; dec_alu_op = OpSub; end
                6'h02: is_j   = 1'b1;
                6'h03: is_jal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                StFetch:  if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    if (is_halt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (!legal) begin
                        state_q   <= StHalt;
                        illegal_q <= 1'b1;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (is_lw || is_sw) state_q <= StMem;
                    else if (is_alu)    state_q <= StWb;
                    else                state_q <= StFetch;
                end
                StMem:   if (mem_ready) state_q <= is_lw ? StWb : StFetch;
                StWb:    state_q <= StFetch;
                StHalt:  state_q <= StHalt;
                default: state_q <= StFetch;
            endcase
        end
    end

    // Outputs are gated by rst_n so an asserted reset silences them without a clock edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_iord   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'd0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        wb_sel     = 2'd0;
        ext_sel    = 2'd3;
        alu_src_b  = 1'b0;
        alu_op     = OpAdd;
        instr_done = 1'b0;
        if (rst_n) begin
            if (state_q inside {StDecode, StExec, StMem, StWb}) ext_sel = dec_ext;
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                StExec: begin
                    alu_op    = dec_alu_op;
                    alu_src_b = dec_src_b;
                    if (is_beq || is_bne) begin
                        pc_src     = 2'd1;
                        pc_we      = is_beq ? alu_zero : ~alu_zero;
                        instr_done = 1'b1;
                    end else if (is_j || is_jal) begin
                        pc_src     = 2'd2;
                        pc_we      = 1'b1;
                        reg_we     = is_jal;
                        reg_dst    = is_jal ? 2'd2 : 2'd0;
                        wb_sel     = is_jal ? 2'd2 : 2'd0;
                        instr_done = 1'b1;
                    end else if (is_jr) begin
                        pc_src     = 2'd3;
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                StMem: begin
                    mem_req    = 1'b1;
                    mem_iord   = 1'b1;
                    mem_we     = is_sw;
                    instr_done = is_sw & mem_ready;
                end
                StWb: begin
                    reg_we     = 1'b1;
                    reg_dst    = {1'b0, is_rtype};
                    wb_sel     = {1'b0, is_lw};
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: HALT_FUNCT, default 6'h0C, R-type funct code (syscall) that halts the core.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 ir  input  32  current instruction register contents, stable from DECODE until instruction end.
REQ-005 mem_ready  input  1  memory completion; a transfer completes in any cycle with mem_req=1 and mem_ready=1.
REQ-006 alu_zero  input  1  ALU result-equals-zero flag, valid in EXEC.
REQ-007 mem_req, mem_we, mem_iord  output  1 each  memory request, write enable, address select (0=PC, 1=ALU out).
REQ-008 ir_we, pc_we  output  1 each  IR load strobe, PC load strobe.
REQ-009 pc_src  output  2  PC source: 0=PC+4, 1=branch target, 2=jump target, 3=rs (jr).
REQ-010 reg_we  output  1; reg_dst  output  2 (0=rt, 1=rd, 2=$31); wb_sel  output  2 (0=ALU, 1=mem data, 2=PC+4).
REQ-011 ext_sel  output  2  immediate extender select: 0=zero-ext imm16, 1=sign-ext imm16, 2=sign-ext shamt ir[10:6], 3=constant 0.
REQ-012 alu_src_b  output  1 (0=rt, 1=extended imm); alu_op  output  4  ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLL=6, SRL=7, SRA=8, LUI=9.
REQ-013 state  output  3; instr_done  output  1; halted  output  1; illegal  output  1.

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; state output mirrors the register.
REQ-015 FETCH: mem_req=1, mem_iord=0; on mem_ready assert ir_we=1, pc_we=1, pc_src=0 that cycle and go to DECODE; otherwise hold FETCH.
REQ-016 DECODE: one cycle, no strobes; opcode ir[31:26] and funct ir[5:0] SHALL select the path; unsupported encoding -> HALT with illegal=1.
REQ-017 Supported: R-type add/addu/sub/subu/and/or/xor/slt/sll/srl/sra/jr/HALT_FUNCT; I-type addi/addiu/slti/andi/ori/xori/lui/lw/sw/beq/bne; J-type j/jal.
REQ-018 ext_sel SHALL be combinational from ir during DECODE..WB: andi/ori/xori/lui=0; addi/addiu/slti/lw/sw/beq/bne=1; sll/srl/sra=2; all else=3.
REQ-019 EXEC ALU ops (R and I) -> WB; lw/sw: alu_op=ADD, alu_src_b=1 -> MEM.
REQ-020 EXEC beq/bne: alu_op=SUB; pc_we=1, pc_src=1 only if (beq & alu_zero) or (bne & ~alu_zero); instruction ends.
REQ-021 EXEC j: pc_we=1, pc_src=2; jal additionally reg_we=1, reg_dst=2, wb_sel=2; jr: pc_we=1, pc_src=3; all end in EXEC.
REQ-022 MEM: mem_req=1, mem_iord=1, mem_we=1 for sw; hold until mem_ready; sw ends on completion, lw -> WB.
REQ-023 WB: reg_we=1 for exactly one cycle; reg_dst=1 for R-type else 0; wb_sel=1 for lw else 0; instruction ends.
REQ-024 Instruction end SHALL pulse instr_done=1 for one cycle and enter FETCH next cycle.
REQ-025 Latency without wait states: branch/jump 3 cycles, ALU/sw 4, lw 5; each mem_ready=0 cycle adds one cycle.
REQ-026 HALT_FUNCT in DECODE -> HALT with halted=1; HALT is absorbing until reset; no strobes or mem_req in HALT.
REQ-027 Outputs mem_we, ir_we, pc_we, reg_we SHALL never be 1 outside the states named above; mem_req SHALL be 1 only in FETCH/MEM.
REQ-028 mem_ready while mem_req=0 SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately force state=FETCH, halted=0, illegal=0, instr_done=0, and all strobes 0, including mid-transfer or in HALT.
REQ-030 First rising edge with rst_n=1 begins a FETCH (mem_req=1 that cycle).

Verification
REQ-031 addi 0x2008FFFF, mem_ready always 1 -> states 0,1,2,4; ext_sel=1, alu_op=0, alu_src_b=1; reg_we=1 in cycle 4; instr_done in cycle 4.
REQ-032 lw 0x8D090004, mem_ready low 2 cycles in FETCH and 1 in MEM -> 8 cycles total; ir_we once, reg_we once with wb_sel=1.
REQ-033 beq 0x11090003 with alu_zero=1 then alu_zero=0 -> pc_we/pc_src=1 in EXEC first case only; both 3 cycles.
REQ-034 sll 0x00084080 -> ext_sel=2, alu_op=6, reg_dst=1; ori 0x3508F0F0 -> ext_sel=0, alu_op=3.
REQ-035 ir=0x0000000C -> HALT, halted=1 held 20 cycles, no mem_req; opcode 0x3F -> HALT with illegal=1.
REQ-036 rst_n dropped asynchronously in MEM of sw -> mem_req/mem_we fall without clock edge; restart in FETCH.
